// File: rtl/pq_req_arbiter.sv
// Two-requester round-robin arbiter sequencing one transaction at a time to the priority-queue core.
// Optional watchdog: define PQ_ARB_WATCHDOG_EN to abort transactions after TIMEOUT cycles.
module pq_req_arbiter #(
    parameter int KW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_op,
    input  logic [2*KW-1:0] req_key,
    output logic [1:0]    req_ready,
    output logic [1:0]    rsp_valid,
    output logic          rsp_err,
    output logic [KW-1:0] rsp_key,
    output logic          pq_valid,
    output logic          pq_op,
    output logic [KW-1:0] pq_key,
    input  logic          pq_ready,
    input  logic          pq_rvalid,
    input  logic [KW-1:0] pq_rkey,
    input  logic          pq_full,
    input  logic          pq_empty,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          lp_q, g_q, op_q, err_q;
    logic [KW-1:0] key_q, rkey_q;

    logic any, both, g, g_op, reject, done, fire;

    assign any    = |req_valid;
    assign both   = &req_valid;
    assign g      = both ? ~lp_q : req_valid[1];
    assign g_op   = req_op[g];
    assign reject = g_op ? pq_empty : pq_full;
    assign done   = ((state_q == ISSUE) && pq_ready && pq_rvalid) ||
                    ((state_q == WAIT) && pq_rvalid);

`ifdef PQ_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic          to_q;

    // Completion in the same cycle as the last allowed cycle still wins.
    assign fire = ((state_q == ISSUE) || (state_q == WAIT)) &&
                  !done && (cnt_q == T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (state_q == IDLE)
                cnt_q <= '0;
            else if ((state_q == ISSUE) || (state_q == WAIT))
                cnt_q <= cnt_q + 1'b1;
            if (fire)
                to_q <= 1'b1;
        end
    end

    assign timeout = to_q;
`else
    logic timeout_unused;

    assign timeout_unused = |TIMEOUT;
    assign fire           = 1'b0;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any) state_d = reject ? RESP : ISSUE;
            ISSUE: begin
                if (done || fire)
                    state_d = RESP;
                else if (pq_ready)
                    state_d = WAIT;
            end
            WAIT: if (done || fire) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lp_q   <= 1'b1;
            g_q    <= 1'b0;
            op_q   <= 1'b0;
            key_q  <= '0;
            err_q  <= 1'b0;
            rkey_q <= '0;
        end else begin
            if ((state_q == IDLE) && any) begin
                lp_q   <= g;
                g_q    <= g;
                err_q  <= reject;
                rkey_q <= '0;
                if (!reject) begin
                    op_q  <= g_op;
                    key_q <= g ? req_key[2*KW-1:KW] : req_key[KW-1:0];
                end
            end
            if (done) begin
                err_q  <= 1'b0;
                rkey_q <= op_q ? pq_rkey : '0;
            end else if (fire) begin
                err_q  <= 1'b1;
                rkey_q <= '0;
            end
        end
    end

    // req_ready is combinational, so it is masked while reset is held.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        rsp_key   = '0;
        if (rst && (state_q == IDLE) && any)
            req_ready = g ? 2'b10 : 2'b01;
        if (state_q == RESP) begin
            rsp_valid = g_q ? 2'b10 : 2'b01;
            rsp_err   = err_q;
            rsp_key   = rkey_q;
        end
    end

    assign pq_valid = (state_q == ISSUE);
    assign pq_op    = op_q;
    assign pq_key   = key_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pq_req_arbiter.sv
// Directed testbench for pq_req_arbiter.
// Watchdog checks follow PQ_ARB_WATCHDOG_EN as seen by the design.
module tb_pq_req_arbiter;

    localparam int KW = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_op;
    logic [2*KW-1:0] req_key;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic          rsp_err;
    logic [KW-1:0] rsp_key;
    logic          pq_valid;
    logic          pq_op;
    logic [KW-1:0] pq_key;
    logic          pq_ready;
    logic          pq_rvalid;
    logic [KW-1:0] pq_rkey;
    logic          pq_full;
    logic          pq_empty;
    logic          busy;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    pq_req_arbiter #(.KW(KW), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_key   (rsp_key),
        .pq_valid  (pq_valid),
        .pq_op     (pq_op),
        .pq_key    (pq_key),
        .pq_ready  (pq_ready),
        .pq_rvalid (pq_rvalid),
        .pq_rkey   (pq_rkey),
        .pq_full   (pq_full),
        .pq_empty  (pq_empty),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b01;
        req_op = 2'b00;
        req_key = 8'h00;
        pq_ready = 1'b0;
        pq_rvalid = 1'b0;
        pq_rkey = '0;
        pq_full = 1'b0;
        pq_empty = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_key, pq_valid, pq_op,
             pq_key, busy, timeout} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got rr=%b rv=%b pv=%b busy=%b to=%b exp all 0",
                     req_ready, rsp_valid, pq_valid, busy, timeout);
        end
        nx();
        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_insert();
        nx();
        req_valid = 2'b01;
        req_op = 2'b00;
        req_key = 8'h09;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL ins_ready got %b exp 01", req_ready);
        end
        nx();
        req_valid = 2'b00;
        pq_ready = 1'b1;
        #1;
        checks++;
        if ({pq_valid, pq_op, pq_key, busy} !== {1'b1, 1'b0, 4'h9, 1'b1}) begin
            errors++;
            $display("FAIL ins_issue got pv=%b op=%b key=%h busy=%b exp 1 0 9 1",
                     pq_valid, pq_op, pq_key, busy);
        end
        nx();
        pq_ready = 1'b0;
        pq_rvalid = 1'b1;
        #1;
        checks++;
        if ({pq_valid, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL ins_wait got pv=%b rv=%b exp 0 00", pq_valid, rsp_valid);
        end
        nx();
        pq_rvalid = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_key} !== {2'b01, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL ins_resp got rv=%b err=%b key=%h exp 01 0 0",
                     rsp_valid, rsp_err, rsp_key);
        end
        nx();
        #1;
        checks++;
        if ({busy, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL ins_done got busy=%b rv=%b exp 0 00", busy, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]    exp_g;
        logic [KW-1:0] exp_k;
        nx();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        req_op = 2'b00;
        req_key = 8'hA5;
        pq_ready = 1'b1;
        pq_rvalid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_k = (k % 2 == 0) ? 4'h5 : 4'hA;
            if (k > 0) begin
                nx();
                #1;
            end
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL b2b_grant%0d got %b exp %b", k, req_ready, exp_g);
            end
            nx();
            #1;
            checks++;
            if ({pq_valid, pq_key, req_ready} !== {1'b1, exp_k, 2'b00}) begin
                errors++;
                $display("FAIL b2b_issue%0d got pv=%b key=%h rr=%b exp 1 %h 00",
                         k, pq_valid, pq_key, req_ready, exp_k);
            end
            nx();
            #1;
            checks++;
            if ({rsp_valid, rsp_err} !== {exp_g, 1'b0}) begin
                errors++;
                $display("FAIL b2b_resp%0d got rv=%b err=%b exp %b 0",
                         k, rsp_valid, rsp_err, exp_g);
            end
        end
        nx();
        req_valid = 2'b00;
        pq_ready = 1'b0;
        pq_rvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reject();
        nx();
        req_valid = 2'b10;
        req_op = 2'b10;
        pq_empty = 1'b1;
        #1;
        checks++;
        if ({req_ready, pq_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rej_empty_ready got rr=%b pv=%b exp 10 0", req_ready, pq_valid);
        end
        nx();
        req_valid = 2'b00;
        pq_empty = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_key, pq_valid} !== {2'b10, 1'b1, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rej_empty_resp got rv=%b err=%b key=%h pv=%b exp 10 1 0 0",
                     rsp_valid, rsp_err, rsp_key, pq_valid);
        end
        nx();
        req_valid = 2'b01;
        req_op = 2'b00;
        req_key = 8'h07;
        pq_full = 1'b1;
        #1;
        checks++;
        if ({busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rej_full_ready got busy=%b rr=%b exp 0 01", busy, req_ready);
        end
        nx();
        req_valid = 2'b00;
        pq_full = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, pq_valid} !== {2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rej_full_resp got rv=%b err=%b pv=%b exp 01 1 0",
                     rsp_valid, rsp_err, pq_valid);
        end
        nx();
        #1;
    endtask

    task automatic test_stall_remove();
        int held;
        nx();
        req_valid = 2'b01;
        req_op = 2'b01;
        req_key = 8'h00;
        pq_rkey = 4'h3;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rem_ready got %b exp 01", req_ready);
        end
        held = 0;
        for (int i = 0; i < 5; i++) begin
            nx();
            req_valid = 2'b00;
            #1;
            if (pq_valid === 1'b1 && pq_op === 1'b1) held++;
        end
        checks++;
        if (held !== 5) begin
            errors++;
            $display("FAIL rem_stall_held got %0d cycles exp 5", held);
        end
        nx();
        pq_ready = 1'b1;
        #1;
        checks++;
        if (pq_valid !== 1'b1) begin
            errors++;
            $display("FAIL rem_accept got pv=%b exp 1", pq_valid);
        end
        nx();
        pq_ready = 1'b0;
        pq_rvalid = 1'b1;
        #1;
        nx();
        pq_rvalid = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_key} !== {2'b01, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL rem_resp got rv=%b err=%b key=%h exp 01 0 3",
                     rsp_valid, rsp_err, rsp_key);
        end
        nx();
        #1;
    endtask

    task automatic test_reset_wait();
        nx();
        req_valid = 2'b10;
        req_op = 2'b00;
        req_key = 8'h70;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rw_ready got %b exp 10", req_ready);
        end
        nx();
        req_valid = 2'b00;
        pq_ready = 1'b1;
        #1;
        nx();
        pq_ready = 1'b0;
        #1;
        checks++;
        if ({busy, pq_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rw_in_wait got busy=%b pv=%b exp 1 0", busy, pq_valid);
        end
        req_valid = 2'b11;
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_key, pq_valid, pq_op,
             pq_key, busy, timeout} !== 16'h0) begin
            errors++;
            $display("FAIL rw_async_reset got rr=%b rv=%b pv=%b busy=%b exp all 0",
                     req_ready, rsp_valid, pq_valid, busy);
        end
        nx();
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rw_post_grant got %b exp 01", req_ready);
        end
        nx();
        req_valid = 2'b00;
        pq_ready = 1'b1;
        pq_rvalid = 1'b1;
        #1;
        nx();
        pq_ready = 1'b0;
        pq_rvalid = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err} !== 3'b010) begin
            errors++;
            $display("FAIL rw_post_resp got rv=%b err=%b exp 01 0", rsp_valid, rsp_err);
        end
        nx();
        #1;
    endtask

    task automatic test_watchdog();
        int seen;
        int cycles;
        nx();
        req_valid = 2'b01;
        req_op = 2'b00;
        req_key = 8'h01;
        pq_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, timeout} !== 3'b010) begin
            errors++;
            $display("FAIL wd_start got rr=%b to=%b exp 01 0", req_ready, timeout);
        end
        seen = 0;
        cycles = 0;
`ifdef PQ_ARB_WATCHDOG_EN
        for (int i = 1; i <= 200 && seen == 0; i++) begin
            nx();
            req_valid = 2'b00;
            #1;
            if (rsp_valid !== 2'b00) begin
                seen = 1;
                cycles = i;
            end
        end
        checks++;
        if (cycles !== 65) begin
            errors++;
            $display("FAIL wd_latency got %0d cycles exp 65", cycles);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_key, timeout, pq_valid} !==
            {2'b01, 1'b1, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wd_resp got rv=%b err=%b key=%h to=%b pv=%b exp 01 1 0 1 0",
                     rsp_valid, rsp_err, rsp_key, timeout, pv_str(pq_valid));
        end
        nx();
        pq_ready = 1'b0;
        pq_rvalid = 1'b1;
        pq_rkey = 4'h5;
        #1;
        nx();
        pq_rvalid = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, timeout} !== 4'b0001) begin
            errors++;
            $display("FAIL wd_late_rvalid got busy=%b rv=%b to=%b exp 0 00 1",
                     busy, rsp_valid, timeout);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            nx();
            req_valid = 2'b00;
            #1;
            if (rsp_valid !== 2'b00) seen = 1;
        end
        cycles = 100;
        checks++;
        if ({seen[0], busy, timeout} !== 3'b010) begin
            errors++;
            $display("FAIL wd_off_hang got seen=%0d busy=%b to=%b over %0d cycles exp 0 1 0",
                     seen, busy, timeout, cycles);
        end
        pq_ready = 1'b0;
`endif
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL wd_reset_clear got busy=%b to=%b exp 0 0", busy, timeout);
        end
        nx();
        rst = 1'b1;
        #1;
    endtask

    function automatic logic pv_str(input logic v);
        return v;
    endfunction

    initial begin
        test_reset();
        test_insert();
        test_back_to_back();
        test_reject();
        test_stall_remove();
        test_reset_wait();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
